// File: rtl/lcd_ctrl_if.sv
// Command-side handshake between display formatting logic and lcd_ctrl.
// The formatter drives a byte plus register-select; the controller answers
// with cmd_ready when it can take the byte this cycle.
interface lcd_ctrl_if;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;

  // Producer of LCD writes (formatting logic / testbench)
  modport master (
    output cmd_valid,
    output cmd_rs,
    output cmd_data,
    input  cmd_ready
  );

  // The LCD controller itself
  modport slave (
    input  cmd_valid,
    input  cmd_rs,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-class character LCD controller, 8-bit bus, write-only.
// After reset it waits out the power-up delay, plays a fixed four-command
// init sequence, then accepts one command/character write at a time and
// generates the RS/EN/DATA bus with enable-pulse and execution-wait timing.
// Every LCD-side output is a flop so the pins never glitch mid-pulse.
module lcd_ctrl #(
  parameter int         EN_PULSE_CYC   = 24,
  parameter int         CMD_WAIT_CYC   = 2500,
  parameter int         CLR_WAIT_CYC   = 82000,
  parameter int         PWRUP_WAIT_CYC = 750000,
  parameter logic [7:0] FUNC_SET       = 8'h38,
  parameter logic [7:0] DISP_CTRL      = 8'h0C,
  parameter logic [7:0] ENTRY_MODE     = 8'h06,
  parameter int         CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  lcd_ctrl_if.slave  cmd_if,
  output logic       busy_o,
  output logic       init_done_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic [7:0] lcd_data_o
);

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_SETUP,
    ST_EN_HI,
    ST_WAIT,
    ST_IDLE
  } state_t;

  // Terminal counts: the timer runs 0..N-1 in each timed state.
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);
  localparam logic [1:0]       INIT_LAST  = 2'd3;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       init_idx_q, init_idx_d;
  logic             in_init_q, in_init_d;
  logic             init_done_q, init_done_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic             is_slow_cmd;
  logic [CNT_W-1:0] wait_last;
  logic             accept;

  // Init sequence ROM: function set, display control, clear, entry mode.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = FUNC_SET;
      2'd1:    init_byte = DISP_CTRL;
      2'd2:    init_byte = 8'h01;
      default: init_byte = ENTRY_MODE;
    endcase
  endfunction

  // Clear and return-home are the only instructions with the long execution
  // time; the same byte sent as character data uses the normal wait.
  assign is_slow_cmd = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
  assign wait_last   = is_slow_cmd ? CLR_LAST : CMD_LAST;

  // ready_q is high exactly while in IDLE, so this is the handshake.
  assign accept = cmd_if.cmd_valid && ready_q;

  // Next-state, latched-byte and output decode for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + CNT_W'(1);
    init_idx_d  = init_idx_q;
    in_init_d   = in_init_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;

    case (state_q)
      ST_PWRUP: begin
        if (timer_q == PWRUP_LAST) begin
          state_d    = ST_SETUP;
          init_idx_d = 2'd0;
          in_init_d  = 1'b1;
          rs_d       = 1'b0;
          data_d     = init_byte(2'd0);
        end
      end

      ST_SETUP: begin
        state_d = ST_EN_HI;
      end

      ST_EN_HI: begin
        if (timer_q == EN_LAST) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (timer_q == wait_last) begin
          if (in_init_q && (init_idx_q != INIT_LAST)) begin
            state_d    = ST_SETUP;
            init_idx_d = init_idx_q + 2'd1;
            rs_d       = 1'b0;
            data_d     = init_byte(init_idx_q + 2'd1);
          end else begin
            state_d = ST_IDLE;
            if (in_init_q) begin
              in_init_d   = 1'b0;
              init_done_d = 1'b1;
            end
          end
        end
      end

      ST_IDLE: begin
        timer_d = '0;
        if (accept) begin
          state_d = ST_SETUP;
          rs_d    = cmd_if.cmd_rs;
          data_d  = cmd_if.cmd_data;
        end
      end

      default: begin
        state_d = ST_PWRUP;
      end
    endcase

    // Every state starts its own timing from zero.
    if (state_d != state_q) begin
      timer_d = '0;
    end

    // Outputs are decoded from the state being entered so that the flops
    // present them in the same cycle the state register does.
    en_d    = (state_d == ST_EN_HI);
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, timer, latched byte and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PWRUP;
      timer_q     <= '0;
      init_idx_q  <= 2'd0;
      in_init_q   <= 1'b1;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      en_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      init_idx_q  <= init_idx_d;
      in_init_q   <= in_init_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      en_q        <= en_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_if.cmd_ready = ready_q;
  assign busy_o           = busy_q;
  assign init_done_o      = init_done_q;
  assign lcd_rs_o         = rs_q;
  assign lcd_rw_o         = 1'b0;
  assign lcd_en_o         = en_q;
  assign lcd_data_o       = data_q;

endmodule
